// File: rtl/axil_reg_slave_if.sv
`default_nettype none
// =============================================================================
// axil_reg_slave_if : AXI4-Lite channel bundle (AW/W/B/AR/R) | Rev 1.0
// =============================================================================
interface axil_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_valid;
    logic                    w_ready;
    logic [1:0]              b_resp;
    logic                    b_valid;
    logic                    b_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface
`default_nettype wire

// File: rtl/axil_reg_slave.sv
`default_nettype none
// =============================================================================
// axil_reg_slave : AXI4-Lite register bank with byte strobes and write pulses | Rev 1.0
// =============================================================================
module axil_reg_slave #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                                 axi_clk_i,
    input  logic                                 axi_arst_ni,
    axil_reg_slave_if.slave                      axi,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_o,
    output logic [NUM_REGS-1:0]                  wr_pulse_o
);
    localparam int                  BPW      = DATA_WIDTH / 8;
    localparam int                  ADDR_LSB = $clog2(BPW);
    localparam int                  IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] SPAN     = (ADDR_WIDTH+1)'(NUM_REGS * BPW);
    localparam logic [1:0]          OKAY     = 2'b00;
    localparam logic [1:0]          SLVERR   = 2'b10;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = (addr - BASE_ADDR) >> ADDR_LSB;
        return IDX_W'(off);
    endfunction

    logic                  aw_full;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [BPW-1:0]        w_strb_q;
    logic                  b_valid_q;
    logic [1:0]            b_resp_q;
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;

    logic                  commit;
    logic                  wr_in;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_in;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_prot;

    assign unused_prot  = ^{axi.aw_prot, axi.ar_prot};

    assign axi.aw_ready = ~aw_full;
    assign axi.w_ready  = ~w_full;
    assign axi.ar_ready = ~r_valid_q;
    assign axi.b_valid  = b_valid_q;
    assign axi.b_resp   = b_resp_q;
    assign axi.r_valid  = r_valid_q;
    assign axi.r_data   = r_data_q;
    assign axi.r_resp   = r_resp_q;

    // A held B response stalls the commit; AW and W can still each buffer one beat.
    assign commit = aw_full & w_full & ~b_valid_q;
    assign wr_in  = in_range(aw_addr_q);
    assign wr_idx = reg_idx(aw_addr_q);
    assign rd_in  = in_range(axi.ar_addr);
    assign rd_idx = reg_idx(axi.ar_addr);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_mux = reg_o[i];
        end
    end

    always_ff @(posedge axi_clk_i or negedge axi_arst_ni) begin
        if (!axi_arst_ni) begin
            aw_full    <= 1'b0;
            aw_addr_q  <= '0;
            w_full     <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= OKAY;
            reg_o      <= {NUM_REGS{RESET_VAL}};
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (axi.aw_valid && !aw_full) begin
                aw_full   <= 1'b1;
                aw_addr_q <= axi.aw_addr;
            end
            if (axi.w_valid && !w_full) begin
                w_full   <= 1'b1;
                w_data_q <= axi.w_data;
                w_strb_q <= axi.w_strb;
            end
            if (commit) begin
                aw_full   <= 1'b0;
                w_full    <= 1'b0;
                b_valid_q <= 1'b1;
                b_resp_q  <= wr_in ? OKAY : SLVERR;
                if (wr_in) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_idx == IDX_W'(i)) begin
                            wr_pulse_o[i] <= 1'b1;
                            for (int b = 0; b < BPW; b++) begin
                                if (w_strb_q[b]) reg_o[i][8*b +: 8] <= w_data_q[8*b +: 8];
                            end
                        end
                    end
                end
            end else if (b_valid_q && axi.b_ready) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // rd_mux reads the pre-edge register value, so a same-edge commit is not visible.
    always_ff @(posedge axi_clk_i or negedge axi_arst_ni) begin
        if (!axi_arst_ni) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= OKAY;
        end else if (axi.ar_valid && !r_valid_q) begin
            r_valid_q <= 1'b1;
            r_data_q  <= rd_in ? rd_mux : '0;
            r_resp_q  <= rd_in ? OKAY : SLVERR;
        end else if (r_valid_q && axi.r_ready) begin
            r_valid_q <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// =============================================================================
// tb_axil_reg_slave : directed + randomized checks against a register-array model | Rev 1.0
// =============================================================================
module tb_axil_reg_slave;
    localparam int          NREG = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] RST  = 32'h5A5A_1234;

    logic clk = 1'b0;
    logic rst_n;
    logic [NREG-1:0][31:0] reg_o;
    logic [NREG-1:0]       wr_pulse;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [NREG];

    axil_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axil_reg_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREG),
        .BASE_ADDR(BASE), .RESET_VAL(RST)
    ) dut (
        .axi_clk_i  (clk),
        .axi_arst_ni(rst_n),
        .axi        (axi),
        .reg_o      (reg_o),
        .wr_pulse_o (wr_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREG; i++) chk($sformatf("%s_reg%0d", tag, i), reg_o[i], model[i]);
    endtask

    function automatic bit m_in(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(NREG * 4));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [15:0] pulse);
        if (m_in(a)) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[m_idx(a)][8*b +: 8] = d[8*b +: 8];
            resp  = 2'b00;
            pulse = 16'(1) << m_idx(a);
        end else begin
            resp  = 2'b10;
            pulse = 16'h0;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) model[i] = RST;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [15:0] pulse);
        int n;
        axi.aw_addr  = a;
        axi.aw_prot  = 3'($urandom_range(0, 7));
        axi.aw_valid = 1'b1;
        axi.w_data   = d;
        axi.w_strb   = s;
        axi.w_valid  = 1'b1;
        axi.b_ready  = 1'b1;
        n = 0;
        while (!(axi.aw_ready && axi.w_ready) && n < 50) begin tick(); n++; end
        chk("wr_accept_in_time", 32'(n < 50), 32'd1);
        tick();
        axi.aw_valid = 1'b0;
        axi.w_valid  = 1'b0;
        n = 0;
        while (!axi.b_valid && n < 50) begin tick(); n++; end
        chk("b_valid_in_time", 32'(n < 50), 32'd1);
        resp  = axi.b_resp;
        pulse = wr_pulse;
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        axi.ar_addr  = a;
        axi.ar_prot  = 3'($urandom_range(0, 7));
        axi.ar_valid = 1'b1;
        axi.r_ready  = 1'b1;
        n = 0;
        while (!axi.ar_ready && n < 50) begin tick(); n++; end
        chk("ar_accept_in_time", 32'(n < 50), 32'd1);
        tick();
        axi.ar_valid = 1'b0;
        chk("r_valid_latency", 32'(axi.r_valid), 32'd1);
        d    = axi.r_data;
        resp = axi.r_resp;
        tick();
    endtask

    initial begin
        logic [31:0] rd, old, a, d;
        logic [1:0]  rs, exp_rs;
        logic [15:0] pl, exp_pl;
        logic [3:0]  s;

        rst_n = 1'b0;
        axi.aw_addr = '0; axi.aw_prot = '0; axi.aw_valid = 1'b0;
        axi.w_data = '0;  axi.w_strb = '0;  axi.w_valid = 1'b0; axi.b_ready = 1'b0;
        axi.ar_addr = '0; axi.ar_prot = '0; axi.ar_valid = 1'b0; axi.r_ready = 1'b0;
        m_reset();
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        check_regs("reset");
        chk("reset_b_valid", 32'(axi.b_valid), 32'd0);
        chk("reset_r_valid", 32'(axi.r_valid), 32'd0);
        chk("reset_r_data", axi.r_data, 32'd0);
        chk("reset_aw_ready", 32'(axi.aw_ready), 32'd1);
        chk("reset_w_ready", 32'(axi.w_ready), 32'd1);
        chk("reset_ar_ready", 32'(axi.ar_ready), 32'd1);
        chk("reset_pulse", 32'(wr_pulse), 32'd0);

        // Full write to reg 2 with exact cycle-by-cycle latency
        axi.b_ready = 1'b1;
        axi.aw_addr = BASE + 32'd8; axi.aw_valid = 1'b1;
        axi.w_data = 32'hDEAD_BEEF; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
        tick();
        axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
        chk("wr1_n1_b_valid", 32'(axi.b_valid), 32'd0);
        chk("wr1_n1_pulse", 32'(wr_pulse), 32'd0);
        chk("wr1_n1_aw_ready", 32'(axi.aw_ready), 32'd0);
        tick();
        m_write(BASE + 32'd8, 32'hDEAD_BEEF, 4'hF, exp_rs, exp_pl);
        chk("wr1_n2_b_valid", 32'(axi.b_valid), 32'd1);
        chk("wr1_n2_b_resp", 32'(axi.b_resp), 32'(exp_rs));
        chk("wr1_n2_reg2", reg_o[2], model[2]);
        chk("wr1_n2_pulse", 32'(wr_pulse), 32'(exp_pl));
        tick();
        chk("wr1_n3_b_valid", 32'(axi.b_valid), 32'd0);
        chk("wr1_n3_pulse", 32'(wr_pulse), 32'd0);
        chk("wr1_n3_aw_ready", 32'(axi.aw_ready), 32'd1);
        do_read(BASE + 32'd8, rd, rs);
        chk("rd1_data", rd, model[2]);
        chk("rd1_resp", 32'(rs), 32'd0);

        // W two cycles ahead of AW, partial strobes
        axi.w_data = 32'h1122_3344; axi.w_strb = 4'b0101; axi.w_valid = 1'b1;
        tick();
        axi.w_valid = 1'b0;
        chk("wfirst_w_ready0", 32'(axi.w_ready), 32'd0);
        chk("wfirst_aw_ready", 32'(axi.aw_ready), 32'd1);
        tick();
        chk("wfirst_w_ready1", 32'(axi.w_ready), 32'd0);
        chk("wfirst_no_b", 32'(axi.b_valid), 32'd0);
        axi.aw_addr = BASE + 32'd8; axi.aw_valid = 1'b1;
        tick();
        axi.aw_valid = 1'b0;
        chk("wfirst_w_ready2", 32'(axi.w_ready), 32'd0);
        tick();
        m_write(BASE + 32'd8, 32'h1122_3344, 4'b0101, exp_rs, exp_pl);
        chk("wfirst_b_valid", 32'(axi.b_valid), 32'd1);
        chk("wfirst_reg2", reg_o[2], model[2]);
        chk("wfirst_w_ready3", 32'(axi.w_ready), 32'd1);
        tick();

        // Range boundaries
        do_write(BASE + 32'(NREG * 4), 32'h0BAD_0BAD, 4'hF, rs, pl);
        chk("oor_hi_wr_resp", 32'(rs), 32'd2);
        chk("oor_hi_pulse", 32'(pl), 32'd0);
        check_regs("oor_hi");
        do_read(BASE + 32'(NREG * 4), rd, rs);
        chk("oor_hi_rd_data", rd, 32'd0);
        chk("oor_hi_rd_resp", 32'(rs), 32'd2);
        do_write(BASE - 32'd4, 32'h0BAD_0BAD, 4'hF, rs, pl);
        chk("oor_lo_wr_resp", 32'(rs), 32'd2);
        chk("oor_lo_pulse", 32'(pl), 32'd0);
        do_read(BASE - 32'd4, rd, rs);
        chk("oor_lo_rd_data", rd, 32'd0);
        chk("oor_lo_rd_resp", 32'(rs), 32'd2);
        do_write(BASE + 32'(NREG * 4 - 1), 32'h7777_8888, 4'hF, rs, pl);
        m_write(BASE + 32'(NREG * 4 - 1), 32'h7777_8888, 4'hF, exp_rs, exp_pl);
        chk("last_reg_resp", 32'(rs), 32'(exp_rs));
        chk("last_reg_pulse", 32'(pl), 32'(exp_pl));
        check_regs("last_reg");

        // B backpressure with a second write buffered behind it
        axi.b_ready = 1'b0;
        axi.aw_addr = BASE + 32'd20; axi.aw_valid = 1'b1;
        axi.w_data = 32'h0000_0005; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
        tick();
        axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
        tick();
        tick();
        m_write(BASE + 32'd20, 32'h0000_0005, 4'hF, exp_rs, exp_pl);
        chk("bp_first_b_valid", 32'(axi.b_valid), 32'd1);
        chk("bp_first_reg5", reg_o[5], model[5]);
        old = model[6];
        axi.aw_addr = BASE + 32'd24; axi.aw_valid = 1'b1;
        axi.w_data = 32'h0000_0006; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
        tick();
        axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_hold%0d_b_valid", i), 32'(axi.b_valid), 32'd1);
            chk($sformatf("bp_hold%0d_aw_ready", i), 32'(axi.aw_ready), 32'd0);
            chk($sformatf("bp_hold%0d_w_ready", i), 32'(axi.w_ready), 32'd0);
            chk($sformatf("bp_hold%0d_reg6", i), reg_o[6], old);
            if (i < 3) tick();
        end
        axi.b_ready = 1'b1;
        tick();
        chk("bp_after_hs_b_valid", 32'(axi.b_valid), 32'd0);
        chk("bp_after_hs_reg6", reg_o[6], old);
        tick();
        m_write(BASE + 32'd24, 32'h0000_0006, 4'hF, exp_rs, exp_pl);
        chk("bp_second_b_valid", 32'(axi.b_valid), 32'd1);
        chk("bp_second_reg6", reg_o[6], model[6]);
        chk("bp_second_pulse", 32'(wr_pulse), 32'(exp_pl));
        tick();

        // R backpressure
        axi.r_ready = 1'b0;
        axi.ar_addr = BASE + 32'd20; axi.ar_valid = 1'b1;
        tick();
        axi.ar_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rbp%0d_r_valid", i), 32'(axi.r_valid), 32'd1);
            chk($sformatf("rbp%0d_ar_ready", i), 32'(axi.ar_ready), 32'd0);
            chk($sformatf("rbp%0d_r_data", i), axi.r_data, model[5]);
            tick();
        end
        axi.r_ready = 1'b1;
        tick();
        chk("rbp_release_r_valid", 32'(axi.r_valid), 32'd0);
        chk("rbp_release_ar_ready", 32'(axi.ar_ready), 32'd1);

        // Read sampled on the commit edge of a write to the same register
        old = model[3];
        axi.aw_addr = BASE + 32'd12; axi.aw_valid = 1'b1;
        axi.w_data = 32'hCAFE_F00D; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
        tick();
        axi.aw_valid = 1'b0; axi.w_valid = 1'b0;
        axi.ar_addr = BASE + 32'd12; axi.ar_valid = 1'b1;
        tick();
        axi.ar_valid = 1'b0;
        m_write(BASE + 32'd12, 32'hCAFE_F00D, 4'hF, exp_rs, exp_pl);
        chk("race_r_valid", 32'(axi.r_valid), 32'd1);
        chk("race_r_data_old", axi.r_data, old);
        chk("race_b_valid", 32'(axi.b_valid), 32'd1);
        chk("race_reg3_new", reg_o[3], model[3]);
        tick();
        do_read(BASE + 32'd12, rd, rs);
        chk("race_followup_data", rd, model[3]);

        // Reset with a held B, a held R and a buffered write outstanding
        axi.b_ready = 1'b0; axi.r_ready = 1'b0;
        axi.aw_addr = BASE + 32'd28; axi.aw_valid = 1'b1;
        axi.w_data = 32'h1357_9BDF; axi.w_strb = 4'hF; axi.w_valid = 1'b1;
        tick();
        axi.aw_addr = BASE + 32'd32;
        tick();
        tick();
        chk("pre_rst_b_valid", 32'(axi.b_valid), 32'd1);
        axi.ar_addr = BASE + 32'd28; axi.ar_valid = 1'b1;
        tick();
        axi.aw_valid = 1'b0; axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
        chk("pre_rst_r_valid", 32'(axi.r_valid), 32'd1);
        chk("pre_rst_aw_full", 32'(axi.aw_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("async_rst_b_valid", 32'(axi.b_valid), 32'd0);
        chk("async_rst_r_valid", 32'(axi.r_valid), 32'd0);
        chk("async_rst_reg7", reg_o[7], model[7]);
        @(negedge clk);
        rst_n = 1'b1;
        axi.b_ready = 1'b1; axi.r_ready = 1'b1;
        tick();
        check_regs("post_rst");
        chk("post_rst_aw_ready", 32'(axi.aw_ready), 32'd1);
        chk("post_rst_w_ready", 32'(axi.w_ready), 32'd1);
        chk("post_rst_ar_ready", 32'(axi.ar_ready), 32'd1);
        chk("post_rst_r_data", axi.r_data, 32'd0);
        chk("post_rst_b_resp", 32'(axi.b_resp), 32'd0);
        chk("post_rst_pulse", 32'(wr_pulse), 32'd0);
        tick(); tick(); tick();
        chk("post_rst_discarded_b", 32'(axi.b_valid), 32'd0);
        chk("post_rst_discarded_reg8", reg_o[8], model[8]);

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            a = BASE - 32'd8 + 32'($urandom_range(0, NREG * 4 + 15));
            if ($urandom_range(0, 2) != 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, rs, pl);
                m_write(a, d, s, exp_rs, exp_pl);
                chk($sformatf("rnd%0d_wr_resp", it), 32'(rs), 32'(exp_rs));
                chk($sformatf("rnd%0d_wr_pulse", it), 32'(pl), 32'(exp_pl));
                check_regs($sformatf("rnd%0d", it));
            end else begin
                do_read(a, rd, rs);
                chk($sformatf("rnd%0d_rd_data", it), rd, m_in(a) ? model[m_idx(a)] : 32'd0);
                chk($sformatf("rnd%0d_rd_resp", it), 32'(rs), m_in(a) ? 32'd0 : 32'd2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
